// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register for CPU inter-stage boundaries.
// An OUT entry drives the outputs and a SKID entry absorbs the one bundle that
// arrives while downstream stalls. Because ready_o is decoded only from the
// registered occupancy, a stall advances one stage per cycle and never forms a
// combinational ready chain.
module pipe_stage_reg #(
    parameter int                 DATA_W      = 64,
    parameter int                 CTRL_W      = 2,
    parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    // Occupancy: EMPTY = no entries, ONE = OUT full, TWO = OUT and SKID full.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [CTRL_W-1:0]   out_ctrl_q, out_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;

    logic                in_xfer;
    logic                out_xfer;

    // Handshake outputs are pure decodes of the registered state.
    assign valid_o  = (state_q != ST_EMPTY);
    assign ready_o  = (state_q != ST_TWO);
    assign data_o   = out_data_q;
    // A bubble must never carry live control bits such as a register write.
    assign ctrl_o   = valid_o ? out_ctrl_q : BUBBLE_CTRL;

    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & ready_i;

    // Next-state and entry-load logic; flush overrides every transfer.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a signal unassigned and infer a latch.
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_ctrl_d  = out_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d    = ST_ONE;
                        out_data_d = data_i;
                        out_ctrl_d = ctrl_i;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        out_data_d = data_i;
                        out_ctrl_d = ctrl_i;
                    end else if (in_xfer) begin
                        state_d     = ST_TWO;
                        skid_data_d = data_i;
                        skid_ctrl_d = ctrl_i;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // ready_o is low here, so only the drain path exists.
                    if (out_xfer) begin
                        state_d    = ST_ONE;
                        out_data_d = skid_data_q;
                        out_ctrl_d = skid_ctrl_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and entry registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: the data entries are reset too, so data_o reads zero after reset
        // and no stale bundle from before a mid-stream reset can survive.
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            out_data_q  <= '0;
            out_ctrl_q  <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_ctrl_q  <= out_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, bubbles, stall/skid,
// flush and simultaneous in/out, all against hand-computed expectations.
module tb_pipe_stage_reg;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 2;

    logic              clk_i;
    logic              rst_i;
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic              flush_i;
    logic              valid_o;
    logic              ready_i;
    logic [DATA_W-1:0] data_o;
    logic [CTRL_W-1:0] ctrl_o;

    int checks;
    int errors;

    pipe_stage_reg #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .BUBBLE_CTRL (2'b00)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .ctrl_i  (ctrl_i),
        .flush_i (flush_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .ctrl_o  (ctrl_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic r,
                              input logic [63:0] d, input logic [1:0] c);
        check({tag, ".valid"}, {63'd0, valid_o}, {63'd0, v});
        check({tag, ".ready"}, {63'd0, ready_o}, {63'd0, r});
        check({tag, ".ctrl"},  {62'd0, ctrl_o},  {62'd0, c});
        if (v) check({tag, ".data"}, data_o, d);
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [1:0] c);
        valid_i = v;
        data_i  = d;
        ctrl_i  = c;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_i   = 1'b1;
        flush_i = 1'b0;
        ready_i = 1'b0;
        drive(1'b0, 64'd0, 2'b00);

        // Reset values, before any clock edge.
        #3;
        expect_out("rst0", 1'b0, 1'b1, 64'd0, 2'b00);
        check("rst0.data", data_o, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Streaming 1..8 with ready_i high: 1-cycle latency, ready stays up.
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 64'(i), 2'(i));
            step();
            expect_out($sformatf("stream%0d", i), 1'b1, 1'b1, 64'(i), 2'(i));
        end
        drive(1'b0, 64'd0, 2'b11);
        step();
        expect_out("stream_end", 1'b0, 1'b1, 64'd0, 2'b00);
        check("stream_end.hold", data_o, 64'd8);

        // Bubble in the middle of a stream with ctrl_i = 2'b11.
        drive(1'b1, 64'h10, 2'b11);
        step();
        expect_out("bub_a", 1'b1, 1'b1, 64'h10, 2'b11);
        drive(1'b0, 64'h10, 2'b11);
        step();
        expect_out("bub_slot", 1'b0, 1'b1, 64'd0, 2'b00);
        drive(1'b1, 64'h11, 2'b11);
        step();
        expect_out("bub_b", 1'b1, 1'b1, 64'h11, 2'b11);
        drive(1'b0, 64'd0, 2'b00);
        step();
        expect_out("bub_end", 1'b0, 1'b1, 64'd0, 2'b00);

        // Stall/skid: A to OUT, B to SKID, C held upstream.
        ready_i = 1'b0;
        drive(1'b1, 64'hA0, 2'b01);
        step();
        expect_out("skid_a", 1'b1, 1'b1, 64'hA0, 2'b01);
        drive(1'b1, 64'hB0, 2'b10);
        step();
        expect_out("skid_b", 1'b1, 1'b0, 64'hA0, 2'b01);
        drive(1'b1, 64'hDD, 2'b11);
        step();
        expect_out("skid_hold1", 1'b1, 1'b0, 64'hA0, 2'b01);
        drive(1'b1, 64'hC0, 2'b11);
        step();
        expect_out("skid_hold2", 1'b1, 1'b0, 64'hA0, 2'b01);
        ready_i = 1'b1;
        step();
        expect_out("drain_b", 1'b1, 1'b1, 64'hB0, 2'b10);
        step();
        expect_out("drain_c", 1'b1, 1'b1, 64'hC0, 2'b11);
        drive(1'b0, 64'd0, 2'b00);
        step();
        expect_out("drain_end", 1'b0, 1'b1, 64'd0, 2'b00);

        // Simultaneous in/out while in ONE.
        ready_i = 1'b0;
        drive(1'b1, 64'h55, 2'b01);
        step();
        expect_out("sim_55", 1'b1, 1'b1, 64'h55, 2'b01);
        ready_i = 1'b1;
        drive(1'b1, 64'hAA, 2'b10);
        step();
        expect_out("sim_aa", 1'b1, 1'b1, 64'hAA, 2'b10);
        drive(1'b0, 64'd0, 2'b00);
        step();
        expect_out("sim_end", 1'b0, 1'b1, 64'd0, 2'b00);

        // Flush in TWO with a bundle presented: everything is dropped.
        ready_i = 1'b0;
        drive(1'b1, 64'h61, 2'b01);
        step();
        drive(1'b1, 64'h62, 2'b10);
        step();
        expect_out("fl_two", 1'b1, 1'b0, 64'h61, 2'b01);
        drive(1'b1, 64'h63, 2'b11);
        flush_i = 1'b1;
        step();
        expect_out("fl_now", 1'b0, 1'b1, 64'd0, 2'b00);
        flush_i = 1'b0;
        ready_i = 1'b1;
        drive(1'b0, 64'd0, 2'b00);
        step();
        expect_out("fl_after1", 1'b0, 1'b1, 64'd0, 2'b00);
        step();
        expect_out("fl_after2", 1'b0, 1'b1, 64'd0, 2'b00);
        drive(1'b1, 64'h70, 2'b01);
        step();
        expect_out("fl_new", 1'b1, 1'b1, 64'h70, 2'b01);

        // Asynchronous reset mid-operation while in TWO.
        ready_i = 1'b0;
        drive(1'b1, 64'h71, 2'b10);
        step();
        expect_out("ar_two", 1'b1, 1'b0, 64'h70, 2'b01);
        drive(1'b0, 64'd0, 2'b00);
        #2;
        rst_i = 1'b1;
        #1;
        expect_out("ar_async", 1'b0, 1'b1, 64'd0, 2'b00);
        check("ar_async.data", data_o, 64'd0);
        @(negedge clk_i);
        rst_i   = 1'b0;
        ready_i = 1'b1;
        step();
        expect_out("ar_idle", 1'b0, 1'b1, 64'd0, 2'b00);
        drive(1'b1, 64'h80, 2'b11);
        step();
        expect_out("ar_new", 1'b1, 1'b1, 64'h80, 2'b11);
        drive(1'b0, 64'd0, 2'b00);
        step();
        expect_out("ar_end", 1'b0, 1'b1, 64'd0, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
